// File: rtl/cp0_pkg.sv
// Shared CP0 constants, exception codes, FSM state type and register packing helpers.
package cp0_pkg;

  localparam logic [4:0]  REG_STATUS  = 5'd12;
  localparam logic [4:0]  REG_CAUSE   = 5'd13;
  localparam logic [4:0]  REG_EPC     = 5'd14;
  localparam logic [4:0]  REG_PRID    = 5'd15;

  localparam logic [4:0]  EXC_INT     = 5'd0;
  localparam logic [4:0]  EXC_SYS     = 5'd8;

  localparam logic [31:0] HANDLER_VEC = 32'h8000_0180;
  localparam logic [31:0] PRID_VAL    = 32'h0001_8000;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    TRAP = 2'd1,
    RET  = 2'd2
  } cp0_state_e;

  function automatic logic [31:0] status_word(input logic [5:0] im, input logic exl,
                                              input logic ie);
    return {16'h0000, im, 8'h00, exl, ie};
  endfunction

  function automatic logic [31:0] cause_word(input logic [5:0] ip, input logic [4:0] exc);
    return {16'h0000, ip, 3'b000, exc, 2'b00};
  endfunction

endpackage

// File: rtl/cp0_int_ctl.sv
// Sticky interrupt-pending latch (Cause.IP) and pending-interrupt qualification.
module cp0_int_ctl
  import cp0_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] int_i,
  input  logic       ip_wr_i,
  input  logic [5:0] ip_wdata_i,
  input  logic [5:0] im_i,
  input  logic       ie_i,
  input  logic       exl_i,
  output logic [5:0] ip_o,
  output logic       pending_o
);

  logic [5:0] ip_q, ip_d;

  // Live lines are ORed after the mtc0 write so an asserted line can never be cleared.
  always_comb begin
    ip_d = (ip_wr_i ? ip_wdata_i : ip_q) | int_i;
  end

  always_ff @(posedge clk) begin
    if (rst) ip_q <= '0;
    else     ip_q <= ip_d;
  end

  assign ip_o      = ip_q;
  assign pending_o = ie_i & ~exl_i & (|((ip_q | int_i) & im_i));

endmodule

// File: rtl/cp0_unit.sv
// CP0 subset: Status/Cause/EPC/PRId, syscall and interrupt entry, eret, fetch redirect.
module cp0_unit
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  input  logic        mtc0,
  input  logic        eret,
  input  logic        syscall,
  input  logic [5:0]  int_in,
  output logic [31:0] cp0out,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        exl
);

  cp0_state_e  state_q, state_d;
  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d, ie_q, ie_d;
  logic [4:0]  exc_q, exc_d;
  logic [31:0] epc_q, epc_d;
  logic [5:0]  ip;
  logic        pending, run, take_int, take_sys, do_eret, do_mtc0, ip_wr;

  cp0_int_ctl u_int_ctl (
    .clk        (clk),
    .rst        (rst),
    .int_i      (int_in),
    .ip_wr_i    (ip_wr),
    .ip_wdata_i (cp0_wdata[15:10]),
    .im_i       (im_q),
    .ie_i       (ie_q),
    .exl_i      (exl_q),
    .ip_o       (ip),
    .pending_o  (pending)
  );

  // Priority: interrupt > syscall > eret > mtc0; only RUN acts on the instruction.
  assign run      = (state_q == RUN);
  assign take_int = run & pending;
  assign take_sys = run & syscall & ~pending;
  assign do_eret  = run & eret & ~pending & ~syscall;
  assign do_mtc0  = run & mtc0 & ~pending & ~syscall & ~eret;
  assign ip_wr    = do_mtc0 & (cp0_addr == REG_CAUSE);

  always_comb begin
    state_d = RUN;
    im_d    = im_q;
    exl_d   = exl_q;
    ie_d    = ie_q;
    exc_d   = exc_q;
    epc_d   = epc_q;
    if (take_int || take_sys) begin
      state_d = TRAP;
      epc_d   = pc;
      exl_d   = 1'b1;
      exc_d   = take_int ? EXC_INT : EXC_SYS;
    end else if (do_eret) begin
      state_d = RET;
      exl_d   = 1'b0;
    end else if (do_mtc0) begin
      case (cp0_addr)
        REG_STATUS: begin
          im_d  = cp0_wdata[15:10];
          exl_d = cp0_wdata[1];
          ie_d  = cp0_wdata[0];
        end
        REG_CAUSE: exc_d = cp0_wdata[6:2];
        REG_EPC:   epc_d = cp0_wdata;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      im_q    <= '0;
      exl_q   <= 1'b0;
      ie_q    <= 1'b0;
      exc_q   <= '0;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      im_q    <= im_d;
      exl_q   <= exl_d;
      ie_q    <= ie_d;
      exc_q   <= exc_d;
      epc_q   <= epc_d;
    end
  end

  always_comb begin
    redirect    = 1'b0;
    redirect_pc = '0;
    case (state_q)
      TRAP: begin
        redirect    = 1'b1;
        redirect_pc = HANDLER_VEC;
      end
      RET: begin
        redirect    = 1'b1;
        redirect_pc = epc_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (cp0_addr)
      REG_STATUS: cp0out = status_word(im_q, exl_q, ie_q);
      REG_CAUSE:  cp0out = cause_word(ip, exc_q);
      REG_EPC:    cp0out = epc_q;
      REG_PRID:   cp0out = PRID_VAL;
      default:    cp0out = '0;
    endcase
  end

  assign exl = exl_q;

endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit: register access, syscall, interrupts, priority, reset.
module tb_cp0_unit;

  logic        clk = 1'b0;
  logic        rst, mtc0, eret, syscall;
  logic [31:0] pc, cp0_wdata;
  logic [4:0]  cp0_addr;
  logic [5:0]  int_in;
  logic [31:0] cp0out, redirect_pc;
  logic        redirect, exl;
  int          total = 0;
  int          bad = 0;

  cp0_unit dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .cp0_addr    (cp0_addr),
    .cp0_wdata   (cp0_wdata),
    .mtc0        (mtc0),
    .eret        (eret),
    .syscall     (syscall),
    .int_in      (int_in),
    .cp0out      (cp0out),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .exl         (exl)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mtc0 = 1'b0; eret = 1'b0; syscall = 1'b0; int_in = '0; rst = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cp0_addr = a; cp0_wdata = d; mtc0 = 1'b1;
    step();
    mtc0 = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    cp0_addr = a;
    #1;
    d = cp0out;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    do_reset();
    total++; if (redirect !== 1'b0) begin bad++; $display("FAIL rst_redirect got=%0h exp=0", redirect); end
    total++; if (redirect_pc !== 32'h0) begin bad++; $display("FAIL rst_redirect_pc got=%08h exp=0", redirect_pc); end
    total++; if (exl !== 1'b0) begin bad++; $display("FAIL rst_exl got=%0h exp=0", exl); end
    rd(5'd12, v); total++; if (v !== 32'h0) begin bad++; $display("FAIL rst_status got=%08h exp=00000000", v); end
    rd(5'd13, v); total++; if (v !== 32'h0) begin bad++; $display("FAIL rst_cause got=%08h exp=00000000", v); end
    rd(5'd14, v); total++; if (v !== 32'h0) begin bad++; $display("FAIL rst_epc got=%08h exp=00000000", v); end
  endtask

  task automatic test_mfc0_mtc0();
    logic [31:0] v;
    do_reset();
    wr(5'd12, 32'h0000FC01);
    rd(5'd12, v); total++; if (v !== 32'h0000FC01) begin bad++; $display("FAIL mtc0_status got=%08h exp=0000fc01", v); end
    rd(5'd15, v); total++; if (v !== 32'h00018000) begin bad++; $display("FAIL prid got=%08h exp=00018000", v); end
    rd(5'd3, v);  total++; if (v !== 32'h0) begin bad++; $display("FAIL unimpl_read got=%08h exp=00000000", v); end
    wr(5'd12, 32'hFFFFFFFF);
    rd(5'd12, v); total++; if (v !== 32'h0000FC03) begin bad++; $display("FAIL status_mask got=%08h exp=0000fc03", v); end
    wr(5'd12, 32'h0);
    wr(5'd15, 32'hFFFFFFFF);
    rd(5'd15, v); total++; if (v !== 32'h00018000) begin bad++; $display("FAIL prid_ro got=%08h exp=00018000", v); end
    wr(5'd14, 32'hDEADBEEF);
    rd(5'd14, v); total++; if (v !== 32'hDEADBEEF) begin bad++; $display("FAIL epc_rw got=%08h exp=deadbeef", v); end
    total++; if (redirect !== 1'b0) begin bad++; $display("FAIL mtc0_no_redirect got=%0h exp=0", redirect); end
  endtask

  task automatic test_syscall();
    logic [31:0] v;
    do_reset();
    pc = 32'h00400020; syscall = 1'b1;
    step();
    syscall = 1'b0;
    total++; if (redirect !== 1'b1) begin bad++; $display("FAIL sys_redirect got=%0h exp=1", redirect); end
    total++; if (redirect_pc !== 32'h80000180) begin bad++; $display("FAIL sys_vec got=%08h exp=80000180", redirect_pc); end
    total++; if (exl !== 1'b1) begin bad++; $display("FAIL sys_exl got=%0h exp=1", exl); end
    rd(5'd14, v); total++; if (v !== 32'h00400020) begin bad++; $display("FAIL sys_epc got=%08h exp=00400020", v); end
    rd(5'd13, v); total++; if (v !== 32'h00000020) begin bad++; $display("FAIL sys_cause got=%08h exp=00000020", v); end
    step();
    total++; if (redirect !== 1'b0) begin bad++; $display("FAIL sys_one_cycle got=%0h exp=0", redirect); end
    total++; if (redirect_pc !== 32'h0) begin bad++; $display("FAIL sys_run_pc got=%08h exp=0", redirect_pc); end
    eret = 1'b1;
    step();
    eret = 1'b0;
    total++; if (redirect !== 1'b1 || redirect_pc !== 32'h00400020) begin bad++; $display("FAIL sys_eret got=%0h/%08h exp=1/00400020", redirect, redirect_pc); end
    total++; if (exl !== 1'b0) begin bad++; $display("FAIL sys_eret_exl got=%0h exp=0", exl); end
    step();
    total++; if (redirect !== 1'b0) begin bad++; $display("FAIL sys_ret_done got=%0h exp=0", redirect); end
  endtask

  task automatic test_interrupt();
    logic [31:0] v;
    do_reset();
    wr(5'd12, 32'h00000401);
    pc = 32'h00400100; int_in = 6'b000001;
    step();
    int_in = '0;
    total++; if (redirect !== 1'b1 || redirect_pc !== 32'h80000180) begin bad++; $display("FAIL int_trap got=%0h/%08h exp=1/80000180", redirect, redirect_pc); end
    rd(5'd14, v); total++; if (v !== 32'h00400100) begin bad++; $display("FAIL int_epc got=%08h exp=00400100", v); end
    rd(5'd13, v); total++; if (v !== 32'h00000400) begin bad++; $display("FAIL int_cause got=%08h exp=00000400", v); end
    step();
    int_in = 6'b000001;
    for (int unsigned i = 0; i < 3; i++) begin
      step();
      total++; if (redirect !== 1'b0) begin bad++; $display("FAIL int_masked_by_exl cyc=%0d got=%0h exp=0", i, redirect); end
    end
    int_in = '0;
    eret = 1'b1;
    step();
    eret = 1'b0;
    total++; if (redirect !== 1'b1 || redirect_pc !== 32'h00400100) begin bad++; $display("FAIL int_eret got=%0h/%08h exp=1/00400100", redirect, redirect_pc); end
    total++; if (exl !== 1'b0) begin bad++; $display("FAIL int_eret_exl got=%0h exp=0", exl); end
    pc = 32'h00400200;
    step();
    total++; if (redirect !== 1'b0) begin bad++; $display("FAIL int_ret_done got=%0h exp=0", redirect); end
    step();
    total++; if (redirect !== 1'b1 || redirect_pc !== 32'h80000180) begin bad++; $display("FAIL int_retaken got=%0h/%08h exp=1/80000180", redirect, redirect_pc); end
    rd(5'd14, v); total++; if (v !== 32'h00400200) begin bad++; $display("FAIL int_retaken_epc got=%08h exp=00400200", v); end
  endtask

  task automatic test_priority();
    logic [31:0] v;
    do_reset();
    wr(5'd12, 32'h00000401);
    pc = 32'h00400300; int_in = 6'b000001; syscall = 1'b1;
    cp0_addr = 5'd14; cp0_wdata = 32'h12345678; mtc0 = 1'b1;
    step();
    idle();
    total++; if (redirect !== 1'b1 || exl !== 1'b1) begin bad++; $display("FAIL prio_trap got=%0h/%0h exp=1/1", redirect, exl); end
    rd(5'd13, v); total++; if (v !== 32'h00000400) begin bad++; $display("FAIL prio_cause got=%08h exp=00000400", v); end
    rd(5'd14, v); total++; if (v !== 32'h00400300) begin bad++; $display("FAIL prio_epc got=%08h exp=00400300", v); end
  endtask

  task automatic test_reset_in_trap();
    logic [31:0] v;
    do_reset();
    wr(5'd12, 32'h00000401);
    pc = 32'h00400040; syscall = 1'b1;
    step();
    syscall = 1'b0;
    total++; if (redirect !== 1'b1) begin bad++; $display("FAIL rtrap_enter got=%0h exp=1", redirect); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (redirect !== 1'b0 || redirect_pc !== 32'h0) begin bad++; $display("FAIL rtrap_redirect got=%0h/%08h exp=0/0", redirect, redirect_pc); end
    total++; if (exl !== 1'b0) begin bad++; $display("FAIL rtrap_exl got=%0h exp=0", exl); end
    rd(5'd12, v); total++; if (v !== 32'h0) begin bad++; $display("FAIL rtrap_status got=%08h exp=0", v); end
    rd(5'd13, v); total++; if (v !== 32'h0) begin bad++; $display("FAIL rtrap_cause got=%08h exp=0", v); end
    rd(5'd14, v); total++; if (v !== 32'h0) begin bad++; $display("FAIL rtrap_epc got=%08h exp=0", v); end
    step();
    total++; if (redirect !== 1'b0) begin bad++; $display("FAIL rtrap_stays_run got=%0h exp=0", redirect); end
  endtask

  task automatic test_ip_clear();
    logic [31:0] v;
    do_reset();
    int_in = 6'b000100;
    step();
    int_in = '0;
    step();
    rd(5'd13, v); total++; if (v !== 32'h00001000) begin bad++; $display("FAIL ip_sticky got=%08h exp=00001000", v); end
    int_in = 6'b000100;
    wr(5'd13, 32'h0);
    rd(5'd13, v); total++; if (v !== 32'h00001000) begin bad++; $display("FAIL ip_clear_blocked got=%08h exp=00001000", v); end
    int_in = '0;
    wr(5'd13, 32'h0000003C);
    rd(5'd13, v); total++; if (v !== 32'h0000003C) begin bad++; $display("FAIL ip_clear got=%08h exp=0000003c", v); end
    total++; if (redirect !== 1'b0) begin bad++; $display("FAIL ip_no_trap got=%0h exp=0", redirect); end
  endtask

  initial begin
    pc = '0; cp0_addr = '0; cp0_wdata = '0;
    idle();
    test_reset();
    test_mfc0_mtc0();
    test_syscall();
    test_interrupt();
    test_priority();
    test_reset_in_trap();
    test_ip_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cp0_unit.md
CP0_UNIT -- requirements
Module: cp0_unit

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset, with ports as follows.
REQ-002 SHALL have port `clk`  in  1  system clock, rising edge.
REQ-003 SHALL have port `rst`  in  1  synchronous active-high reset.
REQ-004 SHALL have port `pc`  in  32  PC of the instruction in the current cycle.
REQ-005 SHALL have port `cp0_addr`  in  5  CP0 register number for mfc0/mtc0 (the rd field).
REQ-006 SHALL have port `cp0_wdata`  in  32  mtc0 write data (busb).
REQ-007 SHALL have port `mtc0`  in  1  write strobe.
REQ-008 SHALL have port `eret`  in  1  return-from-exception strobe.
REQ-009 SHALL have port `syscall`  in  1  syscall exception strobe.
REQ-010 SHALL have port `int_in`  in  6  level-sensitive hardware interrupt lines.
REQ-011 SHALL have port `cp0out`  out  32  mfc0 read data, feeding the memtoreg=11 write-back source.
REQ-012 SHALL have port `redirect`  out  1  PC override request to the fetch stage.
REQ-013 SHALL have port `redirect_pc`  out  32  override target.
REQ-014 SHALL have port `exl`  out  1  Status.EXL.

Function
REQ-015 SHALL implement Status (reg 12): IM=bits[15:10], EXL=bit1, IE=bit0; all other bits read 0.
REQ-016 SHALL implement Cause (reg 13): IP=bits[15:10], ExcCode=bits[6:2]; all other bits read 0.
REQ-017 SHALL implement EPC (reg 14) as 32 bits R/W, and PRId (reg 15) as read-only constant 0x00018000.
REQ-018 SHALL drive cp0out combinationally from cp0_addr, returning register values before the current edge; unimplemented numbers read 0x00000000.
REQ-019 SHALL OR int_in into Cause.IP on every edge (sticky); IP bits clear only by an mtc0 to Cause writing 0 to them in the same cycle int_in is low.
REQ-020 SHALL define the pending interrupt as IE & ~EXL & |(IP & IM), evaluated on the register state plus the current int_in.
REQ-021 SHALL use the FSM states RUN, TRAP and RET; reset state is RUN.
REQ-022 In RUN, with an interrupt pending, SHALL on the edge set EPC<=pc, EXL<=1 and ExcCode<=0, and go to TRAP.
REQ-023 In RUN, with syscall and no interrupt pending, SHALL on the edge set EPC<=pc, EXL<=1 and ExcCode<=8, and go to TRAP.
REQ-024 SHALL give an interrupt priority over a simultaneous syscall; the syscall then re-executes after eret.
REQ-025 In RUN, with eret and no exception, SHALL on the edge set EXL<=0 and go to RET; eret with EXL=0 behaves identically.
REQ-026 In RUN, with mtc0 and no exception/eret, SHALL write cp0_wdata to the addressed register on the edge.
REQ-027 SHALL treat writes to PRId and to unimplemented numbers as no-ops.
REQ-028 SHALL let an exception in the same cycle as mtc0 or eret win, with the mtc0/eret discarded.
REQ-029 SHALL assert redirect=1 and redirect_pc=0x80000180 in TRAP, for one cycle, then return to RUN.
REQ-030 SHALL assert redirect=1 and redirect_pc=EPC in RET, for one cycle, then return to RUN.
REQ-031 SHALL drive redirect=0 and redirect_pc=0 in RUN.
REQ-032 In TRAP/RET, SHALL ignore mtc0, eret and syscall, because that cycle's instruction is squashed by the core.
REQ-033 In TRAP/RET, SHALL still latch int_in into IP.
REQ-034 SHALL impose a redirect latency of exactly one cycle after the triggering edge.

Reset
REQ-035 On rst=1 at an edge, SHALL clear Status, Cause and EPC to 0, set state to RUN, drive redirect=0, redirect_pc=0 and exl=0; rst overrides all other inputs.
REQ-036 SHALL abandon a reset asserted in TRAP/RET without completing the redirect.

Structure
REQ-037 SHALL take from shared package cp0_pkg: register numbers (12-15), ExcCode values (INT=0, SYS=8), handler vector 0x80000180, PRId constant, and the FSM state type.
REQ-038 SHALL place the IP latch and pending-interrupt logic (REQ-019, REQ-020) in sub-module cp0_int_ctl.

Verification
REQ-039 SHALL cover mtc0 0x0000FC01 to reg 12, then mfc0 reg 12 -> cp0out=0x0000FC01; mfc0 reg 15 -> 0x00018000; mfc0 reg 3 -> 0.
REQ-040 SHALL cover syscall at pc=0x00400020 -> next cycle redirect=1, redirect_pc=0x80000180; EPC=0x00400020, Cause=0x00000020, exl=1; redirect=0 the cycle after.
REQ-041 SHALL cover Status=0x00000401 with int_in=000001 pulsed 1 cycle at pc=0x00400100 -> TRAP, EPC=0x00400100, Cause.IP[10]=1, ExcCode=0.
REQ-042 SHALL cover that pulse held with EXL=1 -> no second TRAP; eret -> next cycle redirect_pc=0x00400100, then exl=0 and the interrupt is re-taken.
REQ-043 SHALL cover syscall + pending interrupt + mtc0 to EPC, all in the same cycle -> interrupt taken (ExcCode=0), EPC=pc, mtc0 discarded.
REQ-044 SHALL cover rst asserted during TRAP -> next cycle redirect=0, state RUN, and Status/Cause/EPC all 0.
